sysreg_bus_initiator: RTL and testbench
=======================================

// Module: sysreg_bus_initiator
// PURPOSE
//  Initiator end of the core's star-topology system-register bus. Accepts one
//  sysreg read/write request at a time from the execute stage (valid/ready).
//  Drives single-cycle rd_en/wr_en strobes to the sysreg responder and waits
//  for rd_valid on reads. Returns data or a timeout error on a valid/ready
//  response channel.
// PARAMETERS
//  DATA_W   64  sysreg data width
//  TIMEOUT  16  max cycles spent in WAIT_RD before a read is failed (>=2)
// PORTS
//  clk         in   1       core clock; single clock domain
//  rst_n       in   1       asynchronous active-low reset
//  req_valid   in   1       request offered
//  req_ready   out  1       request accepted when valid&ready
//  req_write   in   1       1=write, 0=read
//  req_group   in   5       register group
//  req_regnum  in   3       register number within group
//  req_plevel  in   2       privilege level of the access
//  req_wdata   in   DATA_W  write data
//  rsp_valid   out  1       response available
//  rsp_ready   in   1       response consumed when valid&ready
//  rsp_rdata   out  DATA_W  read data (0 for writes and errors)
//  rsp_err     out  1       1 = read timed out
//  rd_en       out  1       bus read strobe
//  rd_group    out  5       bus read group
//  rd_regnum   out  3       bus read register number
//  rd_plevel   out  2       bus read privilege level
//  rd_valid    in   1       responder read-data valid
//  rd_val      in   DATA_W  responder read data
//  wr_en       out  1       bus write strobe
//  wr_group    out  5       bus write group
//  wr_regnum   out  3       bus write register number
//  wr_plevel   out  2       bus write privilege level
//  wr_val      out  DATA_W  bus write data
//  busy        out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE. req_ready=1 and all other outputs 0, including captured fields and counter.
//  All bus/rsp outputs are registered. The request is captured into holding regs on accept.
//  FSM states: IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, RESP.
//   IDLE: req_ready=1. On req_valid, capture and go to ISSUE_WR (write) or ISSUE_RD (read).
//   ISSUE_WR: wr_en=1 for exactly this cycle; wr_* = captured fields. Next state: RESP with
//    rdata=0, err=0.
//   ISSUE_RD: rd_en=1 for exactly this cycle; rd_* = captured fields. Next state: WAIT_RD, cnt=0.
//   WAIT_RD: rd_valid=1 -> RESP, rdata=rd_val, err=0. Otherwise cnt++.
//    cnt==TIMEOUT-1 with no rd_valid -> RESP, rdata=0, err=1.
//    rd_valid in the final count cycle counts as success (success beats timeout).
//   RESP: rsp_valid=1; rdata/err are held stable until rsp_ready. Then IDLE with rsp_valid=0.
//  req_ready=0 in every state except IDLE; one outstanding access max.
//  Latency (accept in cycle N):
//   Write: wr_en@N+1, rsp_valid@N+2.
//   Read: rd_en@N+1, rsp_valid 1 cycle after rd_valid (earliest N+3).
//   Read timeout: rsp_valid@N+2+TIMEOUT.
//  rd_valid outside WAIT_RD (stray/late) is ignored and never alters rsp_rdata.
//  rd_group/regnum/plevel and wr_* fields hold their last driven values when the strobe is 0.
//   Only the strobes qualify them.
//  rd_en and wr_en are never 1 in the same cycle.
//  Async reset mid-operation: immediate return to reset state. No strobe or rsp is emitted.
//   Any late rd_valid after reset is ignored.
//  busy = (state != IDLE).
// TESTING
//  T1 write g=3,r=1,pl=0,wdata=0xDEAD_BEEF accepted@N -> wr_en=1 only @N+1 with those
//     fields; rsp_valid@N+2, rdata=0, err=0.
//  T2 read g=10,r=7,pl=0; responder rd_valid@N+2 with 0x1234 -> rsp_valid@N+3,
//     rdata=0x1234, err=0.
//  T3 read; rd_valid never asserted, TIMEOUT=16 -> rsp_valid@N+18, rdata=0, err=1;
//     rd_valid@N+20 ignored.
//  T4 read; rd_valid exactly in the last WAIT_RD cycle (N+17) -> success, err=0, data taken.
//  T5 rsp_ready low 3 cycles -> rsp_valid/rdata/err stable; req_ready=0 and a new
//     req_valid is not accepted until after the handshake.
//  T6 rst_n low during WAIT_RD -> all outputs 0 and req_ready=1 immediately. After
//     release, a write completes as in T1.

Source files
------------

// File: rtl/sysreg_bus_initiator.sv
// Initiator side of the system-register bus: takes one request at a time from
// execute, issues a single-cycle rd_en/wr_en strobe and returns data or a read timeout.
module sysreg_bus_initiator #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [4:0]        req_group,
  input  logic [2:0]        req_regnum,
  input  logic [1:0]        req_plevel,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rd_en,
  output logic [4:0]        rd_group,
  output logic [2:0]        rd_regnum,
  output logic [1:0]        rd_plevel,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_val,
  output logic              wr_en,
  output logic [4:0]        wr_group,
  output logic [2:0]        wr_regnum,
  output logic [1:0]        wr_plevel,
  output logic [DATA_W-1:0] wr_val,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE_RD = 3'd1;
  localparam logic [2:0] S_WAIT_RD  = 3'd2;
  localparam logic [2:0] S_ISSUE_WR = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // The bus field registers double as the request holding registers; strobes
  // default low so each one lasts exactly the single issue cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rd_en     <= 1'b0;
      rd_group  <= '0;
      rd_regnum <= '0;
      rd_plevel <= '0;
      wr_en     <= 1'b0;
      wr_group  <= '0;
      wr_regnum <= '0;
      wr_plevel <= '0;
      wr_val    <= '0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (req_write) begin
              wr_en     <= 1'b1;
              wr_group  <= req_group;
              wr_regnum <= req_regnum;
              wr_plevel <= req_plevel;
              wr_val    <= req_wdata;
              state     <= S_ISSUE_WR;
            end else begin
              rd_en     <= 1'b1;
              rd_group  <= req_group;
              rd_regnum <= req_regnum;
              rd_plevel <= req_plevel;
              state     <= S_ISSUE_RD;
            end
          end
        end
        S_ISSUE_WR: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          state     <= S_RESP;
        end
        S_ISSUE_RD: begin
          cnt   <= '0;
          state <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          // A response arriving in the last count cycle still wins over the timeout.
          if (rd_valid) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_val;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysreg_bus_initiator.sv
// Directed bench for sysreg_bus_initiator: write/read latency, timeout edge,
// response back-pressure and mid-read reset.
module tb_sysreg_bus_initiator;

  localparam int DATA_W  = 64;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [4:0]        req_group;
  logic [2:0]        req_regnum;
  logic [1:0]        req_plevel;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rd_en;
  logic [4:0]        rd_group;
  logic [2:0]        rd_regnum;
  logic [1:0]        rd_plevel;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_val;
  logic              wr_en;
  logic [4:0]        wr_group;
  logic [2:0]        wr_regnum;
  logic [1:0]        wr_plevel;
  logic [DATA_W-1:0] wr_val;
  logic              busy;

  int tests  = 0;
  int failed = 0;

  sysreg_bus_initiator #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_group(req_group), .req_regnum(req_regnum), .req_plevel(req_plevel),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rd_en(rd_en), .rd_group(rd_group), .rd_regnum(rd_regnum), .rd_plevel(rd_plevel),
    .rd_valid(rd_valid), .rd_val(rd_val),
    .wr_en(wr_en), .wr_group(wr_group), .wr_regnum(wr_regnum), .wr_plevel(wr_plevel),
    .wr_val(wr_val), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic wr, input logic [4:0] g, input logic [2:0] r,
                       input logic [1:0] pl, input logic [63:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_group  = g;
    req_regnum = r;
    req_plevel = pl;
    req_wdata  = wd;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_group = '0; req_regnum = '0;
    req_plevel = '0; req_wdata = '0; rsp_ready = 1'b1; rd_valid = 1'b0; rd_val = '0;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_val", wr_val, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // T1 write: accept at N
    offer(1'b1, 5'd3, 3'd1, 2'd0, 64'hDEAD_BEEF);
    chk("t1_ready_N", req_ready, 1);
    chk("t1_wr_en_N", wr_en, 0);
    tick(); req_valid = 1'b0;                        // N+1
    chk("t1_wr_en", wr_en, 1);
    chk("t1_wr_group", wr_group, 3);
    chk("t1_wr_regnum", wr_regnum, 1);
    chk("t1_wr_plevel", wr_plevel, 0);
    chk("t1_wr_val", wr_val, 64'hDEAD_BEEF);
    chk("t1_rd_en", rd_en, 0);
    chk("t1_ready_busy", req_ready, 0);
    chk("t1_rsp_early", rsp_valid, 0);
    tick();                                          // N+2
    chk("t1_wr_en_off", wr_en, 0);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rdata", rsp_rdata, 0);
    chk("t1_err", rsp_err, 0);
    chk("t1_wr_hold", wr_group, 3);
    tick();                                          // N+3
    chk("t1_rsp_done", rsp_valid, 0);
    chk("t1_idle", req_ready, 1);

    // T2 read with rd_valid at N+2
    offer(1'b0, 5'd10, 3'd7, 2'd0, 64'h0);
    tick(); req_valid = 1'b0;                        // N+1
    chk("t2_rd_en", rd_en, 1);
    chk("t2_rd_group", rd_group, 10);
    chk("t2_rd_regnum", rd_regnum, 7);
    chk("t2_rd_plevel", rd_plevel, 0);
    chk("t2_wr_en", wr_en, 0);
    tick();                                          // N+2
    chk("t2_rd_en_off", rd_en, 0);
    rd_valid = 1'b1; rd_val = 64'h1234;
    chk("t2_rsp_early", rsp_valid, 0);
    tick(); rd_valid = 1'b0; rd_val = '0;            // N+3
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rdata", rsp_rdata, 64'h1234);
    chk("t2_err", rsp_err, 0);
    tick();
    chk("t2_idle", req_ready, 1);

    // T3 read timeout, stray rd_valid at N+20 ignored
    offer(1'b0, 5'd5, 3'd2, 2'd3, 64'h0);
    tick(); req_valid = 1'b0;                        // N+1
    chk("t3_rd_plevel", rd_plevel, 3);
    for (int i = 0; i < 16; i++) tick();             // N+17
    chk("t3_rsp_not_yet", rsp_valid, 0);
    rsp_ready = 1'b0;
    tick();                                          // N+18
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rdata", rsp_rdata, 0);
    chk("t3_err", rsp_err, 1);
    tick(); tick();                                  // N+20
    rd_valid = 1'b1; rd_val = 64'hBAD0_BAD0;
    tick(); rd_valid = 1'b0;                         // N+21
    chk("t3_stray_rdata", rsp_rdata, 0);
    chk("t3_stray_err", rsp_err, 1);
    chk("t3_hold_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    chk("t3_idle", req_ready, 1);
    chk("t3_rsp_done", rsp_valid, 0);

    // T4 rd_valid in the last WAIT_RD cycle (N+17)
    offer(1'b0, 5'd1, 3'd0, 2'd1, 64'h0);
    tick(); req_valid = 1'b0;                        // N+1
    for (int i = 0; i < 16; i++) tick();             // N+17
    rd_valid = 1'b1; rd_val = 64'hCAFE_F00D_0000_0042;
    chk("t4_rsp_not_yet", rsp_valid, 0);
    tick(); rd_valid = 1'b0; rd_val = '0;            // N+18
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_err", rsp_err, 0);
    chk("t4_rdata", rsp_rdata, 64'hCAFE_F00D_0000_0042);
    tick();
    chk("t4_idle", req_ready, 1);

    // T5 response back-pressure with a competing request
    offer(1'b0, 5'd2, 3'd4, 2'd2, 64'h0);
    tick(); req_valid = 1'b0;                        // N+1
    tick();                                          // N+2
    rd_valid = 1'b1; rd_val = 64'h55AA;
    rsp_ready = 1'b0;
    tick(); rd_valid = 1'b0; rd_val = '0;            // N+3
    offer(1'b1, 5'd1, 3'd6, 2'd1, 64'h77);
    for (int i = 0; i < 3; i++) begin                // N+3..N+5
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_rdata", rsp_rdata, 64'h55AA);
      chk("t5_hold_err", rsp_err, 0);
      chk("t5_no_accept", req_ready, 0);
      chk("t5_no_wr", wr_en, 0);
      tick();
    end
    rsp_ready = 1'b1;                                // N+6
    chk("t5_still_valid", rsp_valid, 1);
    tick();                                          // N+7
    chk("t5_rsp_done", rsp_valid, 0);
    chk("t5_ready_again", req_ready, 1);
    chk("t5_wr_not_yet", wr_en, 0);
    tick(); req_valid = 1'b0;                        // N+8
    chk("t5_wr_en", wr_en, 1);
    chk("t5_wr_group", wr_group, 1);
    chk("t5_wr_val", wr_val, 64'h77);
    tick();
    chk("t5_wr_rsp", rsp_valid, 1);
    tick();

    // T6 reset during WAIT_RD, then a clean write
    offer(1'b0, 5'd9, 3'd3, 2'd1, 64'h0);
    tick(); req_valid = 1'b0;                        // N+1
    tick(); tick();                                  // N+3, in WAIT_RD
    chk("t6_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_req_ready", req_ready, 1);
    chk("t6_rd_group", rd_group, 0);
    chk("t6_rd_en", rd_en, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    tick();
    rst_n = 1'b1;
    rd_valid = 1'b1; rd_val = 64'hFFFF;
    tick(); rd_valid = 1'b0; rd_val = '0;
    chk("t6_late_rsp", rsp_valid, 0);
    chk("t6_late_rdata", rsp_rdata, 0);
    chk("t6_late_busy", busy, 0);
    offer(1'b1, 5'd3, 3'd1, 2'd0, 64'hDEAD_BEEF);
    tick(); req_valid = 1'b0;
    chk("t6_wr_en", wr_en, 1);
    chk("t6_wr_val", wr_val, 64'hDEAD_BEEF);
    tick();
    chk("t6_rsp_valid", rsp_valid, 1);
    chk("t6_err", rsp_err, 0);
    tick();
    chk("t6_idle", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Strobe exclusivity is checked on every clock.
  always @(negedge clk) begin
    if (rd_en && wr_en) begin
      failed++;
      $error("FAIL strobe_excl: observed rd_en=1 wr_en=1 expected not both");
    end
  end

endmodule
